// File: rtl/flash_sequencer.sv
// flash_sequencer: drives an external LED flasher through a programmable
// number of runs. Each run resets the flasher, pulses its start input for
// FLICK_CYC cycles, then watches the LED vector until it lights and goes dark
// again. A run that never finishes within TIMEOUT cycles ends the sequence
// with an error pulse.
module flash_sequencer #(
    parameter int unsigned FLICK_CYC = 2,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_repeat,
    input  logic        cmd_abort,
    output logic        flick,
    output logic        flasher_rst_n,
    input  logic [15:0] led,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [3:0]  runs_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLRST,
        S_ARM,
        S_RUN,
        S_GAP,
        S_FIN,
        S_ABORT
    } state_t;

    // Terminal counts for the shared cycle counter in ARM and RUN.
    localparam logic [15:0] FLICK_LAST   = 16'(FLICK_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic [3:0]  repeat_q, repeat_d;
    logic [3:0]  runs_q, runs_d;
    logic        tout_d;

    logic        flick_q;
    logic        flasher_rst_n_q;
    logic        done_q;
    logic        timeout_err_q;

    logic        abortable;
    logic        run_complete;

    assign abortable    = (state_q == S_FLRST) || (state_q == S_ARM) ||
                          (state_q == S_RUN)   || (state_q == S_GAP);
    assign run_complete = seen_q && (led == 16'd0);

    // Next-state logic: sequencing, counters, run tracking. Abort is applied
    // last so it overrides completion and timeout decided in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        repeat_d = repeat_q;
        runs_d   = runs_q;
        tout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    repeat_d = cmd_repeat;
                    runs_d   = 4'd0;
                    state_d  = (cmd_repeat == 4'd0) ? S_FIN : S_FLRST;
                end
            end
            S_FLRST: begin
                cnt_d   = 16'd0;
                state_d = S_ARM;
            end
            S_ARM: begin
                if (cnt_q == FLICK_LAST) begin
                    cnt_d   = 16'd0;
                    seen_d  = 1'b0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                if (run_complete) begin
                    runs_d  = (runs_q == 4'd15) ? runs_q : runs_q + 4'd1;
                    state_d = (runs_d == repeat_q) ? S_FIN : S_GAP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (led != 16'd0) begin
                        seen_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                cnt_d   = 16'd0;
                state_d = S_ARM;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cmd_abort && abortable) begin
            state_d = S_ABORT;
            runs_d  = runs_q;
            tout_d  = 1'b0;
        end
    end

    // State and output registers; outputs are decoded from the next state so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= 16'd0;
            seen_q          <= 1'b0;
            repeat_q        <= 4'd0;
            runs_q          <= 4'd0;
            flick_q         <= 1'b0;
            flasher_rst_n_q <= 1'b0;
            done_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            seen_q          <= seen_d;
            repeat_q        <= repeat_d;
            runs_q          <= runs_d;
            flick_q         <= (state_d == S_ARM);
            flasher_rst_n_q <= !((state_d == S_FLRST) || (state_d == S_ABORT));
            done_q          <= (state_d == S_FIN);
            timeout_err_q   <= tout_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign flick         = flick_q;
    assign flasher_rst_n = flasher_rst_n_q;
    assign done          = done_q;
    assign timeout_err   = timeout_err_q;
    assign runs_done     = runs_q;

endmodule
